crc32_frame_ctrl: RTL and testbench

Frame-level sequencer for the 32-bit CRC-32 (0x04C11DB7) word engine. Sits between a 32-bit word stream source and sink. It drives the engine's data, enable and clear inputs and reads back its current CRC value. In generate mode it appends the finalized CRC word to each frame; in check mode it verifies the trailing CRC word of each frame and reports pass/fail.

---
 rtl/crc32_frame_ctrl.sv | 140 ++++++++++++++
 tb/tb_crc32_frame_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc32_frame_ctrl.sv
// Frame sequencer for a CRC-32 word engine. In generate mode it appends the final CRC word
// to each frame. In check mode it compares the trailing word of each frame against the engine.
module crc32_frame_ctrl #(
    parameter logic [31:0] FINAL_XOR = 32'hFFFF_FFFF,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chk_mode,
    input  logic [31:0]      s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [31:0]      m_data,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready,
    output logic [31:0]      eng_data_in,
    output logic             eng_en,
    output logic             eng_clr,
    input  logic [31:0]      eng_crc,
    output logic             crc_ok,
    output logic             crc_err,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    typedef enum logic [1:0] {StData, StAppend, StClr} state_e;

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic             sop_q, sop_d;
    logic             pass_q, pass_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic        eff_mode;
    logic        accept;
    logic [31:0] crc_final;

    // The mode is only latched on the first word, so that word uses chk_mode directly.
    assign eff_mode  = sop_q ? chk_mode : mode_q;
    assign accept    = s_valid & m_ready;
    assign crc_final = eng_crc ^ FINAL_XOR;

    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StData;
            mode_q      <= 1'b0;
            sop_q       <= 1'b1;
            pass_q      <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            sop_q       <= sop_d;
            pass_q      <= pass_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        sop_d       = sop_q;
        pass_d      = pass_q;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;

        s_ready     = 1'b0;
        m_valid     = 1'b0;
        m_last      = 1'b0;
        m_data      = s_data;
        eng_data_in = s_data;
        eng_en      = 1'b0;
        eng_clr     = 1'b0;
        crc_ok      = 1'b0;
        crc_err     = 1'b0;

        if (rst) begin
            eng_clr = 1'b1;
        end else begin
            unique case (state_q)
                StData: begin
                    m_valid = s_valid;
                    s_ready = m_ready;
                    m_last  = eff_mode & s_last;
                    // In check mode the trailing CRC word is compared, not folded into the CRC.
                    eng_en  = accept & ~(eff_mode & s_last);
                    if (accept) begin
                        if (sop_q) begin
                            mode_d = chk_mode;
                            sop_d  = 1'b0;
                        end
                        if (s_last) begin
                            if (eff_mode) begin
                                pass_d  = (s_data == crc_final);
                                state_d = StClr;
                            end else begin
                                state_d = StAppend;
                            end
                        end
                    end
                end
                StAppend: begin
                    m_valid = 1'b1;
                    m_last  = 1'b1;
                    m_data  = crc_final;
                    if (m_ready) begin
                        state_d = StClr;
                    end
                end
                StClr: begin
                    eng_clr     = 1'b1;
                    frame_cnt_d = frame_cnt_q + CntOne;
                    if (mode_q) begin
                        crc_ok  = pass_q;
                        crc_err = ~pass_q;
                        if (!pass_q && (err_cnt_q != '1)) begin
                            err_cnt_d = err_cnt_q + CntOne;
                        end
                    end
                    sop_d   = 1'b1;
                    state_d = StData;
                end
                default: begin
                    state_d = StData;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc32_frame_ctrl.sv
// Bench for crc32_frame_ctrl: behavioural CRC engine, output scoreboard, directed frame sequence.
module tb_crc32_frame_ctrl;

    localparam logic [31:0] FX = 32'hFFFF_FFFF;
    localparam logic [31:0] Poly = 32'h04C1_1DB7;

    logic        clk = 1'b0;
    logic        rst;
    logic        chk_mode;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready;
    logic [31:0] eng_data_in;
    logic        eng_en;
    logic        eng_clr;
    logic [31:0] eng_crc = 32'hFFFF_FFFF;
    logic        crc_ok;
    logic        crc_err;
    logic [1:0]  frame_cnt;
    logic [1:0]  err_cnt;

    crc32_frame_ctrl #(
        .FINAL_XOR(FX),
        .CNT_W    (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .chk_mode   (chk_mode),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .eng_data_in(eng_data_in),
        .eng_en     (eng_en),
        .eng_clr    (eng_clr),
        .eng_crc    (eng_crc),
        .crc_ok     (crc_ok),
        .crc_err    (crc_err),
        .frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [31:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 31; i >= 0; i--) begin
            fb = r[31] ^ d[i];
            r  = {r[30:0], 1'b0};
            if (fb) r = r ^ Poly;
        end
        return r;
    endfunction

    // Engine model: clear to all ones, or fold in one word per enabled cycle.
    always_ff @(posedge clk) begin
        if (eng_clr) eng_crc <= 32'hFFFF_FFFF;
        else if (eng_en) eng_crc <= crc_step(eng_crc, eng_data_in);
    end

    typedef struct {
        logic [31:0] d;
        logic        l;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [31:0] fw[$];

    int n_tests = 0;
    int n_fail = 0;
    int en_seen = 0, clr_seen = 0, ok_seen = 0, err_seen = 0;
    int en_base, clr_base, ok_base, err_base;
    int exp_frames = 0, exp_errs = 0;
    bit cur_mode, cur_ok;
    int cur_n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            n_tests++;
            assert (!(eng_en && eng_clr))
            else begin
                n_fail++;
                $error("FAIL en_clr_overlap: observed 1 expected 0");
            end
            if (eng_en) en_seen++;
            if (eng_clr) clr_seen++;
            if (crc_ok) ok_seen++;
            if (crc_err) err_seen++;
            if (m_valid && m_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $error("FAIL unexpected_out: observed %h expected none", m_data);
                end else begin
                    e = exp_q.pop_front();
                    assert (m_data === e.d && m_last === e.l)
                    else begin
                        n_fail++;
                        $error("FAIL out_word: observed %h/%b expected %h/%b",
                               m_data, m_last, e.d, e.l);
                    end
                end
            end
        end
    end

    // Drives fw[] as one frame; the scoreboard gets the expected output words up front.
    task automatic send(input bit mode, input bit toggle, input bit gap);
        logic [31:0] c;
        int          guard;
        cur_n    = fw.size();
        cur_mode = mode;
        clr_base = clr_seen;
        en_base  = en_seen;
        ok_base  = ok_seen;
        err_base = err_seen;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < cur_n; i++) begin
            if (!mode || i < cur_n - 1) c = crc_step(c, fw[i]);
            exp_q.push_back('{d: fw[i], l: (mode && i == cur_n - 1)});
        end
        if (!mode) exp_q.push_back('{d: c ^ FX, l: 1'b1});
        cur_ok = mode && ((c ^ FX) == fw[cur_n-1]);
        for (int i = 0; i < cur_n; i++) begin
            s_data   = fw[i];
            s_valid  = 1'b1;
            s_last   = (i == cur_n - 1);
            chk_mode = (i == 0) ? mode : (toggle ? ~mode : mode);
            guard    = 0;
            @(negedge clk);
            while (!s_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 50) chk("accept_timeout", 32'd1, 32'd0);
            @(posedge clk);
            #1;
            s_valid = 1'b0;
            s_last  = 1'b0;
            if (gap && i < cur_n - 1) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic finish_frame();
        int guard;
        guard = 0;
        while (clr_seen == clr_base && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 50) chk("clr_timeout", 32'd1, 32'd0);
        exp_frames = (exp_frames + 1) % 4;
        if (cur_mode && !cur_ok && exp_errs < 3) exp_errs++;
        chk("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
        chk("err_cnt", 32'(err_cnt), 32'(exp_errs));
        chk("en_cycles", 32'(en_seen - en_base), cur_mode ? 32'(cur_n - 1) : 32'(cur_n));
        chk("clr_cycles", 32'(clr_seen - clr_base), 32'd1);
        chk("ok_pulse", 32'(ok_seen - ok_base), 32'(cur_mode && cur_ok));
        chk("err_pulse", 32'(err_seen - err_base), 32'(cur_mode && !cur_ok));
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        chk_mode = 1'b0;
        s_data   = '0;
        s_valid  = 1'b0;
        s_last   = 1'b0;
        m_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_clr", 32'(eng_clr), 32'd1);
        chk("rst_en", 32'(eng_en), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_ok_err", 32'({crc_ok, crc_err}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        @(posedge clk);
        #1;

        fw = '{32'h0000_0000};
        send(1'b1, 1'b0, 1'b0);
        finish_frame();
        fw = '{32'h0000_0001};
        send(1'b1, 1'b0, 1'b0);
        finish_frame();

        fw = '{32'h1, 32'h2, 32'h3, 32'h4};
        send(1'b0, 1'b0, 1'b0);
        finish_frame();
        fw = '{32'h1, 32'h2, 32'h3, 32'h4,
               crc_step(crc_step(crc_step(crc_step(32'hFFFF_FFFF, 32'h1), 32'h2), 32'h3),
                        32'h4) ^ FX};
        send(1'b1, 1'b0, 1'b1);
        finish_frame();

        // APPEND held off by the sink for three cycles.
        fw = '{32'h5, 32'h6, 32'h7};
        send(1'b0, 1'b0, 1'b0);
        m_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_m_valid", 32'(m_valid), 32'd1);
            chk("bp_m_last", 32'(m_last), 32'd1);
            chk("bp_m_data", m_data, exp_q[0].d);
            chk("bp_s_ready", 32'(s_ready), 32'd0);
            chk("bp_en", 32'(en_seen - en_base), 32'd3);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        finish_frame();

        fw = '{32'h8, 32'h9};
        send(1'b0, 1'b1, 1'b0);
        finish_frame();
        fw = '{32'hA, 32'hB, 32'hBAD};
        send(1'b1, 1'b1, 1'b1);
        finish_frame();
        fw = '{32'h0000_0001};
        send(1'b1, 1'b0, 1'b0);
        finish_frame();
        fw = '{32'h0000_0002};
        send(1'b1, 1'b0, 1'b0);
        finish_frame();

        // Reset while the appended CRC word is stalled.
        fw = '{32'h3, 32'h4};
        send(1'b0, 1'b0, 1'b0);
        m_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_m_valid", 32'(m_valid), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_clr", 32'(eng_clr), 32'd1);
        chk("mid_rst_en", 32'(eng_en), 32'd0);
        chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        m_ready = 1'b1;
        exp_q.delete();
        exp_frames = 0;
        exp_errs   = 0;
        @(negedge clk);
        chk("post_rst_m_valid", 32'(m_valid), 32'd0);
        chk("post_rst_clr", 32'(eng_clr), 32'd0);
        chk("post_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("post_rst_err_cnt", 32'(err_cnt), 32'd0);
        @(posedge clk);
        #1;
        fw = '{32'h0000_0000};
        send(1'b1, 1'b0, 1'b0);
        finish_frame();

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
